rgb_pwm_out: RTL
================

// Module: rgb_pwm_out
// PURPOSE
// Three-channel PWM output stage, directly downstream of the fade block(s). Consumes one
// pwm_value per colour and drives the RGB LED pins. Compare values are double-buffered so that
// mid-period duty changes never produce runt or glitched pulses. Outputs are registered and
// polarity-selectable; the iCE40 RGB pins are active-low.
// PARAMETERS
// PWM_INTERVAL  1200                    PWM period in clk cycles (100 us at 12 MHz); must equal fade's value
// ACTIVE_LOW    1                       1: LED on = pin 0; 0: LED on = pin 1
// DUTY_W        $clog2(PWM_INTERVAL)    width of the duty inputs (matches fade pwm_value)
// PORTS
// clk           in   1       system clock, 12 MHz
// rst_n         in   1       asynchronous, active-low reset
// en            in   1       1: run PWM; 0: hold counter at 0 and drive all LEDs off
// duty_valid    in   1       strobe: capture duty_r/g/b into the shadow registers this cycle
// duty_r        in   DUTY_W  red duty in cycles per period
// duty_g        in   DUTY_W  green duty in cycles per period
// duty_b        in   DUTY_W  blue duty in cycles per period
// pwm_r         out  1       red LED pin (polarity per ACTIVE_LOW)
// pwm_g         out  1       green LED pin
// pwm_b         out  1       blue LED pin
// period_start  out  1       one-cycle pulse, coincident with pins reflecting cnt==0
// BEHAVIOUR
// - Reset (async assert, sync release): cnt=0; shadow_*=0; active_*=0; period_start=0;
//   pwm_* = off level (1 if ACTIVE_LOW, else 0).
// - Counter: cnt runs 0..PWM_INTERVAL-1 and wraps to 0 while en=1. Width $clog2(PWM_INTERVAL).
//   While en=0, cnt is forced to 0.
// - Shadow: on every cycle with duty_valid=1, shadow_x <= duty_x, regardless of en.
// - Active load: when en=1 and cnt==PWM_INTERVAL-1, active_x <= next shadow value, so a new duty
//   first governs the period that starts at cnt==0. While en=0, active_x tracks shadow every cycle.
//   If duty_valid is asserted in the load cycle, active_x takes the incoming duty_x (bypass).
// - Compare (per channel, using active_x):
//   - on = (active_x >= PWM_INTERVAL-1) ? 1 : (cnt < active_x).
//   - active_x=0 gives always off.
//   - active_x >= PWM_INTERVAL-1 gives 100% on with no gap. This covers fade's saturated value.
//   - 0 < d < PWM_INTERVAL-1 gives exactly d on-cycles per period, starting at cnt==0.
// - Output: pwm_x <= (en & on) ^ ACTIVE_LOW. One cycle of latency from cnt to the pin.
//   period_start <= en & (cnt==0).
// - en falling: the next edge drives pins off and resets cnt. No partial-period completion.
// - en rising: the first counted period starts at cnt=0 using the current shadow values.
// - Reset mid-period: pins go off asynchronously. After release, operation restarts from cnt=0
//   with zero duty until duty_valid is seen.
// - Non-power-of-2 PWM_INTERVAL: cnt never exceeds PWM_INTERVAL-1. Duty inputs above
//   PWM_INTERVAL-1 saturate to 100% on.
// TESTING (run with PWM_INTERVAL=10, ACTIVE_LOW=1 unless noted)
// 1. Reset, en=1, duty_r=3 strobed -> from the next period, pwm_r low for exactly 3 cycles per 10;
//    period_start pulses every 10 cycles.
// 2. duty_g=0 -> pwm_g held 1. duty_g=9 -> pwm_g held 0. duty_g=15 -> held 0 (saturate).
//    No single-cycle pulses at any of these.
// 3. duty_b=2 running; strobe duty_b=7 at cnt=4 -> the current period keeps 2 on-cycles,
//    the next period has 7.
// 4. Strobe duty_r=5 in the cycle cnt==9 -> the very next period has 5 on-cycles (bypass).
// 5. en dropped at cnt=6 -> all pins 1 on the next edge, period_start stays 0. en raised ->
//    period_start one cycle later, duty from shadow.
// 6. rst_n pulsed low mid-period with duties 4/4/4 -> pins 1 immediately, period_start=0.
//    After release, all pins stay off until a strobe; ACTIVE_LOW=0 rerun shows inverted levels.

Source files
------------

// File: rtl/rgb_pwm_out_if.sv
// Duty-update and LED-pin bundle between the fade logic and the RGB PWM output stage.
// The master drives the run enable and duty strobe; the slave returns the pins and period marker.
interface rgb_pwm_out_if #(
  parameter int DUTY_W = 11
);
  logic              en;
  logic              duty_valid;
  logic [DUTY_W-1:0] duty_r;
  logic [DUTY_W-1:0] duty_g;
  logic [DUTY_W-1:0] duty_b;
  logic              pwm_r;
  logic              pwm_g;
  logic              pwm_b;
  logic              period_start;

  modport master (
    output en, duty_valid, duty_r, duty_g, duty_b,
    input  pwm_r, pwm_g, pwm_b, period_start
  );

  modport slave (
    input  en, duty_valid, duty_r, duty_g, duty_b,
    output pwm_r, pwm_g, pwm_b, period_start
  );
endinterface

// File: rtl/rgb_pwm_out.sv
// Three-channel PWM with double-buffered duty; the pins lag the counter by one cycle.
// A duty strobe is always accepted (there is no backpressure), and a new duty first takes effect at the next period boundary.
module rgb_pwm_out #(
  parameter int PWM_INTERVAL = 1200,
  parameter bit ACTIVE_LOW   = 1'b1,
  parameter int DUTY_W       = $clog2(PWM_INTERVAL)
) (
  input  logic         clk,
  input  logic         rst_n,
  rgb_pwm_out_if.slave bus
);

  localparam logic [DUTY_W-1:0] LAST    = DUTY_W'(PWM_INTERVAL - 1);
  localparam logic              OFF_LVL = ACTIVE_LOW;

  logic [DUTY_W-1:0] cnt;
  logic              cnt_last;
  logic [DUTY_W-1:0] duty_in    [3];
  logic [DUTY_W-1:0] shadow     [3];
  logic [DUTY_W-1:0] shadow_nxt [3];
  logic [DUTY_W-1:0] active     [3];
  logic [2:0]        on;
  logic [2:0]        pin;
  logic              period_start_q;

  assign cnt_last   = (cnt == LAST);
  assign duty_in[0] = bus.duty_r;
  assign duty_in[1] = bus.duty_g;
  assign duty_in[2] = bus.duty_b;

  // A strobe in the load cycle is forwarded straight into the active register.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      shadow_nxt[i] = bus.duty_valid ? duty_in[i] : shadow[i];
    end
  end

  // Any value at or above the last count means solid on, so there is no one-cycle gap.
  always_comb begin
    on = '0;
    for (int i = 0; i < 3; i++) begin
      on[i] = (active[i] >= LAST) ? 1'b1 : (cnt < active[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!bus.en || cnt_last) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // While the stage is disabled, active follows the shadow so that the first period after enable uses the current duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (bus.duty_valid) begin
          shadow[i] <= duty_in[i];
        end
        if (!bus.en || cnt_last) begin
          active[i] <= shadow_nxt[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pin            <= {3{OFF_LVL}};
      period_start_q <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        pin[i] <= (bus.en & on[i]) ^ OFF_LVL;
      end
      period_start_q <= bus.en & (cnt == '0);
    end
  end

  assign bus.pwm_r        = pin[0];
  assign bus.pwm_g        = pin[1];
  assign bus.pwm_b        = pin[2];
  assign bus.period_start = period_start_q;

endmodule
